// File: rtl/data_mem_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | data_mem_arbiter: round-robin 2-port arbiter for the data memory      |
// | Revision: 1.0                                                          |
// +----------------------------------------------------------------------+
module data_mem_arbiter #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0,
  input  logic              req1,
  input  logic              we0,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata0,
  input  logic [DATA_W-1:0] wdata1,
  output logic              gnt0,
  output logic              gnt1,
  output logic              rvalid0,
  output logic              rvalid1,
  output logic [DATA_W-1:0] rdata0,
  output logic [DATA_W-1:0] rdata1,
  output logic [ADDR_W-1:0] mem_address,
  output logic [DATA_W-1:0] mem_writeData,
  output logic              mem_read,
  output logic              mem_write,
  input  logic [DATA_W-1:0] mem_readData
);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_BUSY = 1'b1;

  logic [0:0]        r_state;
  logic [0:0]        w_next_state;
  logic              r_ptr;
  logic              r_win;
  logic              r_we;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;
  logic              r_rvalid0;
  logic              r_rvalid1;
  logic [DATA_W-1:0] r_rdata0;
  logic [DATA_W-1:0] r_rdata1;
  logic              w_any;
  logic              w_pick;

  assign w_any  = req0 | req1;
  // Pointer only matters under contention; a lone requester always wins.
  assign w_pick = (req0 & req1) ? r_ptr : req1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE: if (w_any) w_next_state = ST_BUSY;
      ST_BUSY: w_next_state = ST_IDLE;
      default: w_next_state = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ptr   <= 1'b0;
      r_win   <= 1'b0;
      r_we    <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
    end else if (r_state == ST_IDLE && w_any) begin
      r_win   <= w_pick;
      r_ptr   <= ~w_pick;
      r_we    <= w_pick ? we1 : we0;
      r_addr  <= w_pick ? addr1 : addr0;
      r_wdata <= w_pick ? wdata1 : wdata0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rvalid0 <= 1'b0;
      r_rvalid1 <= 1'b0;
      r_rdata0  <= '0;
      r_rdata1  <= '0;
    end else begin
      r_rvalid0 <= 1'b0;
      r_rvalid1 <= 1'b0;
      if (r_state == ST_BUSY && !r_we) begin
        if (r_win) begin
          r_rvalid1 <= 1'b1;
          r_rdata1  <= mem_readData;
        end else begin
          r_rvalid0 <= 1'b1;
          r_rdata0  <= mem_readData;
        end
      end
    end
  end

  // Memory-side outputs depend only on state and command registers.
  always_comb begin
    gnt0          = 1'b0;
    gnt1          = 1'b0;
    mem_address   = '0;
    mem_writeData = '0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    if (r_state == ST_BUSY) begin
      gnt0          = ~r_win;
      gnt1          = r_win;
      mem_address   = r_addr;
      mem_writeData = r_wdata;
      mem_write     = r_we;
      mem_read      = ~r_we;
    end
  end

  assign rvalid0 = r_rvalid0;
  assign rvalid1 = r_rvalid1;
  assign rdata0  = r_rdata0;
  assign rdata1  = r_rdata1;

endmodule
`default_nettype wire

// File: tb/tb_data_mem_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_data_mem_arbiter: directed self-checking bench for the arbiter     |
// | Revision: 1.0                                                          |
// +----------------------------------------------------------------------+
module tb_data_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        req0, req1, we0, we1;
  logic [9:0]  addr0, addr1;
  logic [15:0] wdata0, wdata1;
  logic        gnt0, gnt1, rvalid0, rvalid1;
  logic [15:0] rdata0, rdata1;
  logic [9:0]  mem_address;
  logic [15:0] mem_writeData;
  logic        mem_read, mem_write;
  logic [15:0] mem_readData;

  logic [15:0] mem [1024];
  logic        tb_init;
  int          n_checks = 0;
  int          n_errors = 0;

  always #5 clk = ~clk;

  data_mem_arbiter #(.ADDR_W(10), .DATA_W(16)) dut (
    .clk(clk), .rst(rst),
    .req0(req0), .req1(req1), .we0(we0), .we1(we1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .gnt0(gnt0), .gnt1(gnt1), .rvalid0(rvalid0), .rvalid1(rvalid1),
    .rdata0(rdata0), .rdata1(rdata1),
    .mem_address(mem_address), .mem_writeData(mem_writeData),
    .mem_read(mem_read), .mem_write(mem_write), .mem_readData(mem_readData)
  );

  // Memory model: combinational read, write on rising edge, preload 500..503 = 1..4.
  assign mem_readData = mem[mem_address];
  always @(posedge clk) begin
    if (tb_init) begin
      for (int i = 0; i < 1024; i++) mem[i] <= '0;
      for (int i = 0; i < 4; i++) mem[500+i] <= 16'(i + 1);
    end else if (mem_write) begin
      mem[mem_address] <= mem_writeData;
    end
  end

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; tb_init = 1'b1;
    req0 = 0; req1 = 0; we0 = 0; we1 = 0;
    addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;
    tick(); tick();
    tb_init = 1'b0;
    chk("rst_gnt0", gnt0, 0);          chk("rst_gnt1", gnt1, 0);
    chk("rst_rvalid0", rvalid0, 0);    chk("rst_rvalid1", rvalid1, 0);
    chk("rst_rdata0", rdata0, 0);      chk("rst_rdata1", rdata1, 0);
    chk("rst_mem_read", mem_read, 0);  chk("rst_mem_write", mem_write, 0);
    chk("rst_mem_addr", mem_address, 0);
    chk("rst_mem_wdata", mem_writeData, 0);
    rst = 1'b0;

    // Single read on port 0
    req0 = 1; we0 = 0; addr0 = 10'd500;
    tick();
    chk("rd_gnt0", gnt0, 1);  chk("rd_gnt1", gnt1, 0);
    chk("rd_mem_read", mem_read, 1);  chk("rd_mem_addr", mem_address, 500);
    req0 = 0;
    tick();
    chk("rd_rvalid0", rvalid0, 1);  chk("rd_rdata0", rdata0, 16'h0001);
    chk("rd_rvalid1", rvalid1, 0);  chk("rd_gnt0_drop", gnt0, 0);
    tick();
    chk("rd_rvalid0_pulse", rvalid0, 0);

    // Port 1 write then read of the top address
    req1 = 1; we1 = 1; addr1 = 10'd1023; wdata1 = 16'hBEEF;
    tick();
    chk("wr_gnt1", gnt1, 1);  chk("wr_mem_write", mem_write, 1);
    chk("wr_mem_read", mem_read, 0);
    chk("wr_mem_addr", mem_address, 1023);  chk("wr_mem_wdata", mem_writeData, 16'hBEEF);
    we1 = 0;
    tick();
    chk("wr_mem_write_1cyc", mem_write, 0);  chk("wr_no_rvalid1", rvalid1, 0);
    chk("wr_committed", mem[1023], 16'hBEEF);
    tick();
    chk("wr_rd_gnt1", gnt1, 1);  chk("wr_rd_mem_read", mem_read, 1);
    req1 = 0;
    tick();
    chk("wr_rd_rvalid1", rvalid1, 1);  chk("wr_rd_rdata1", rdata1, 16'hBEEF);

    // Streaming reads on port 1
    req1 = 1; we1 = 0; addr1 = 10'd500;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("st_gnt1", gnt1, 1);  chk("st_addr", mem_address, 500 + i);
      if (i < 3) addr1 = 10'(501 + i);
      else req1 = 0;
      tick();
      chk("st_rvalid1", rvalid1, 1);  chk("st_rdata1", rdata1, i + 1);
      chk("st_gnt1_idle", gnt1, 0);
    end

    // Fairness: port 1 alone, then both -> port 0
    req1 = 1; we1 = 0; addr1 = 10'd501;
    tick();
    chk("fair_gnt1", gnt1, 1);
    req1 = 0;
    tick();
    chk("fair_rdata1", rdata1, 2);
    req0 = 1; we0 = 0; addr0 = 10'd502;
    req1 = 1; we1 = 0; addr1 = 10'd503;
    tick();
    chk("fair_gnt0", gnt0, 1);  chk("fair_gnt1_lose", gnt1, 0);
    req0 = 0;
    tick();
    chk("fair_rdata0", rdata0, 3);
    tick();
    chk("fair_gnt1_next", gnt1, 1);
    req1 = 0;
    tick();
    chk("fair_rdata1_b", rdata1, 4);

    // Contention after reset
    rst = 1; tick(); rst = 0;
    req0 = 1; we0 = 0; addr0 = 10'd500;
    req1 = 1; we1 = 0; addr1 = 10'd503;
    for (int k = 1; k <= 8; k++) begin
      tick();
      chk("ct_gnt0", gnt0, (k == 1 || k == 5));
      chk("ct_gnt1", gnt1, (k == 3 || k == 7));
      chk("ct_rvalid0", rvalid0, (k == 2 || k == 6));
      chk("ct_rvalid1", rvalid1, (k == 4 || k == 8));
      if (k == 2 || k == 6) chk("ct_rdata0", rdata0, 1);
      if (k == 4 || k == 8) chk("ct_rdata1", rdata1, 4);
      if (k == 7) begin req0 = 0; req1 = 0; end
    end

    // Reset during a write's BUSY cycle
    req0 = 1; we0 = 1; addr0 = 10'd10; wdata0 = 16'h1234;
    tick();
    chk("mr_mem_write", mem_write, 1);  chk("mr_gnt0", gnt0, 1);
    req0 = 0;
    rst = 1;
    #1;
    chk("mr_write_drop", mem_write, 0);  chk("mr_gnt0_drop", gnt0, 0);
    chk("mr_addr0", mem_address, 0);     chk("mr_wdata0", mem_writeData, 0);
    chk("mr_rdata1", rdata1, 0);         chk("mr_rvalid0", rvalid0, 0);
    tick();
    chk("mr_no_rvalid", rvalid0, 0);
    rst = 0;
    chk("mr_no_commit", mem[10], 0);
    req0 = 1; we0 = 0; addr0 = 10'd10;
    req1 = 1; we1 = 0; addr1 = 10'd1023;
    tick();
    chk("mr_ptr_gnt0", gnt0, 1);  chk("mr_ptr_gnt1", gnt1, 0);
    req0 = 0;
    tick();
    chk("mr_rvalid0", rvalid0, 1);  chk("mr_rdata0", rdata0, 0);
    tick();
    chk("mr_gnt1", gnt1, 1);
    req1 = 0;
    tick();
    chk("mr_rdata1_end", rdata1, 16'hBEEF);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
